// File: rtl/app_spi_pkg.sv
// Shared constants for the application-FPGA SPI master: register map,
// register bit positions and FSM state encodings.
package app_spi_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_TXDATA = 2'd1;
  localparam logic [1:0] REG_RXDATA = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_CS_SEL_BIT  = 0;
  localparam int CTRL_CS_HOLD_BIT = 1;
  localparam int CTRL_DIV_LSB     = 8;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_OVR_BIT  = 2;

  typedef logic [2:0] spi_state_t;
  localparam spi_state_t ST_IDLE  = 3'd0;
  localparam spi_state_t ST_SETUP = 3'd1;
  localparam spi_state_t ST_SHIFT = 3'd2;
  localparam spi_state_t ST_HOLD  = 3'd3;
  localparam spi_state_t ST_DONE  = 3'd4;

  // One-hot channel enable: bit 0 = SPI0, bit 1 = SPI1.
  function automatic logic [1:0] chan_onehot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/app_spi_clkgen.sv
// SCK half-period timer: a loadable down-counter that ticks for one cycle
// every div+1 clocks, restartable so the first half-period starts cleanly.
module app_spi_clkgen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_r;

  // Reload on restart or when the current half-period expires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (restart || (cnt_r == '0)) begin
      cnt_r <= div;
    end else begin
      cnt_r <= cnt_r - DIV_W'(1);
    end
  end

  assign tick = (cnt_r == '0);

endmodule

// File: rtl/app_spi_master.sv
// OPB-attached mode-0 SPI master for the two application-FPGA channels:
// register file, transfer FSM, shift registers and bit counter.
module app_spi_master
  import app_spi_pkg::*;
#(
  parameter int DIV_W     = 8,
  parameter int DATA_BITS = 8
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST_N,
  input  logic [31:0] OPB_ADDR,
  input  logic [31:0] OPB_DI,
  output logic [31:0] OPB_DO,
  input  logic        SPI_WE,
  input  logic        SPI_RE,
  output logic        APP_FPGA_SPI_CLK,
  output logic        APP_FPGA_SPI0_CS_N,
  output logic        APP_FPGA_SPI1_CS_N,
  output logic        APP_FPGA_SPI0_MOSI,
  output logic        APP_FPGA_SPI1_MOSI,
  input  logic        APP_FPGA_SPI0_MISO,
  input  logic        APP_FPGA_SPI1_MISO,
  output logic        SPI_IRQ
);

  localparam int CNT_W = $clog2(DATA_BITS) + 1;

  logic [1:0]           reg_sel_s;
  logic                 wr_ctrl_s, wr_tx_s, wr_stat_s, rd_rx_s;
  logic                 accept_ok_s, start_s, ovr_set_s, done_set_s, restart_s, tick_s;
  logic                 ctrl_cs_sel_r, ctrl_cs_hold_r;
  logic [DIV_W-1:0]     ctrl_div_r;
  logic                 done_r, ovr_r, busy_r;
  logic [DATA_BITS-1:0] rxdata_r;
  spi_state_t           state_r;
  logic                 armed_r, cur_sel_r;
  logic [DIV_W-1:0]     cur_div_r;
  logic [DATA_BITS-1:0] tx_shift_r, rx_shift_r, tx_next_s, rx_next_s;
  logic [CNT_W-1:0]     bit_cnt_r;
  logic                 sck_r, cs0_n_r, cs1_n_r, mosi0_r, mosi1_r, irq_r;
  logic [31:0]          rd_data_s, opb_do_r;
  logic [1:0]           chan_en_s;
  logic                 miso_s;
  logic                 unused_s;

  assign reg_sel_s   = OPB_ADDR[3:2];
  assign wr_ctrl_s   = SPI_WE && (reg_sel_s == REG_CTRL);
  assign wr_tx_s     = SPI_WE && (reg_sel_s == REG_TXDATA);
  assign wr_stat_s   = SPI_WE && (reg_sel_s == REG_STATUS);
  assign rd_rx_s     = SPI_RE && (reg_sel_s == REG_RXDATA);
  // DONE is already "not busy", so a new byte may start there.
  assign accept_ok_s = (state_r == ST_IDLE) || (state_r == ST_DONE);
  assign start_s     = wr_tx_s && accept_ok_s;
  assign ovr_set_s   = wr_tx_s && !accept_ok_s;
  assign done_set_s  = (state_r == ST_HOLD) && tick_s;
  assign restart_s   = (state_r == ST_SETUP) && !armed_r;
  assign chan_en_s   = chan_onehot(cur_sel_r);
  assign miso_s      = cur_sel_r ? APP_FPGA_SPI1_MISO : APP_FPGA_SPI0_MISO;
  assign tx_next_s   = tx_shift_r << 1;
  assign rx_next_s   = (rx_shift_r << 1) | DATA_BITS'(miso_s);
  assign unused_s    = ^{OPB_ADDR[31:4], OPB_ADDR[1:0], OPB_DI};

  app_spi_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk     (OPB_CLK),
    .rst_n   (OPB_RST_N),
    .restart (restart_s),
    .div     (cur_div_r),
    .tick    (tick_s)
  );

  // Read-data mux; RXDATA bypasses to the fresh byte in the done-set cycle.
  always_comb begin
    rd_data_s = 32'd0;
    case (reg_sel_s)
      REG_CTRL: begin
        rd_data_s[CTRL_CS_SEL_BIT]            = ctrl_cs_sel_r;
        rd_data_s[CTRL_CS_HOLD_BIT]           = ctrl_cs_hold_r;
        rd_data_s[CTRL_DIV_LSB +: DIV_W]      = ctrl_div_r;
      end
      REG_RXDATA: rd_data_s[DATA_BITS-1:0]  = done_set_s ? rx_shift_r : rxdata_r;
      REG_STATUS: begin
        rd_data_s[STAT_BUSY_BIT]              = busy_r;
        rd_data_s[STAT_DONE_BIT]              = done_r;
        rd_data_s[STAT_OVR_BIT]               = ovr_r;
      end
      default: rd_data_s = 32'd0;
    endcase
  end

  // Register file, sticky flags and registered read port.
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      ctrl_cs_sel_r  <= 1'b0;
      ctrl_cs_hold_r <= 1'b0;
      ctrl_div_r     <= '0;
      done_r         <= 1'b0;
      ovr_r          <= 1'b0;
      rxdata_r       <= '0;
      opb_do_r       <= 32'd0;
    end else begin
      if (wr_ctrl_s) begin
        ctrl_cs_sel_r  <= OPB_DI[CTRL_CS_SEL_BIT];
        ctrl_cs_hold_r <= OPB_DI[CTRL_CS_HOLD_BIT];
        ctrl_div_r     <= OPB_DI[CTRL_DIV_LSB +: DIV_W];
      end
      if (ovr_set_s)                             ovr_r <= 1'b1;
      else if (wr_stat_s && OPB_DI[STAT_OVR_BIT]) ovr_r <= 1'b0;
      if (done_set_s)   done_r <= 1'b1;
      else if (rd_rx_s) done_r <= 1'b0;
      if (done_set_s) rxdata_r <= rx_shift_r;
      if (SPI_RE)     opb_do_r <= rd_data_s;
    end
  end

  // Transfer FSM driving SCK, chip selects and MOSI from registers.
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      state_r    <= ST_IDLE;
      armed_r    <= 1'b0;
      busy_r     <= 1'b0;
      cur_sel_r  <= 1'b0;
      cur_div_r  <= '0;
      tx_shift_r <= '0;
      rx_shift_r <= '0;
      bit_cnt_r  <= '0;
      sck_r      <= 1'b0;
      cs0_n_r    <= 1'b1;
      cs1_n_r    <= 1'b1;
      mosi0_r    <= 1'b0;
      mosi1_r    <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      irq_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start_s) begin
            state_r    <= ST_SETUP;
            armed_r    <= 1'b0;
            cur_sel_r  <= ctrl_cs_sel_r;
            cur_div_r  <= ctrl_div_r;
            tx_shift_r <= OPB_DI[DATA_BITS-1:0];
            bit_cnt_r  <= '0;
          end else begin
            state_r <= ST_IDLE;
            if (wr_ctrl_s && !OPB_DI[CTRL_CS_HOLD_BIT]) begin
              cs0_n_r <= 1'b1;
              cs1_n_r <= 1'b1;
              mosi0_r <= 1'b0;
              mosi1_r <= 1'b0;
            end
          end
        end
        ST_SETUP: begin
          if (!armed_r) begin
            armed_r <= 1'b1;
            busy_r  <= 1'b1;
            cs0_n_r <= !chan_en_s[0];
            cs1_n_r <= !chan_en_s[1];
            mosi0_r <= chan_en_s[0] & tx_shift_r[DATA_BITS-1];
            mosi1_r <= chan_en_s[1] & tx_shift_r[DATA_BITS-1];
          end else if (tick_s) begin
            sck_r      <= 1'b1;
            rx_shift_r <= rx_next_s;
            state_r    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick_s && !sck_r) begin
            sck_r      <= 1'b1;
            rx_shift_r <= rx_next_s;
          end else if (tick_s) begin
            sck_r <= 1'b0;
            if (bit_cnt_r == CNT_W'(DATA_BITS - 1)) begin
              state_r <= ST_HOLD;
            end else begin
              bit_cnt_r  <= bit_cnt_r + CNT_W'(1);
              tx_shift_r <= tx_next_s;
              mosi0_r    <= chan_en_s[0] & tx_next_s[DATA_BITS-1];
              mosi1_r    <= chan_en_s[1] & tx_next_s[DATA_BITS-1];
            end
          end
        end
        ST_HOLD: begin
          if (tick_s) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            irq_r   <= 1'b1;
            if (!ctrl_cs_hold_r) begin
              cs0_n_r <= 1'b1;
              cs1_n_r <= 1'b1;
              mosi0_r <= 1'b0;
              mosi1_r <= 1'b0;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign OPB_DO             = opb_do_r;
  assign APP_FPGA_SPI_CLK   = sck_r;
  assign APP_FPGA_SPI0_CS_N = cs0_n_r;
  assign APP_FPGA_SPI1_CS_N = cs1_n_r;
  assign APP_FPGA_SPI0_MOSI = mosi0_r;
  assign APP_FPGA_SPI1_MOSI = mosi1_r;
  assign SPI_IRQ            = irq_r;

endmodule

// File: doc/app_spi_master.md
# app_spi_master

Hardware SPI master that sits between the OPB register bus and the application-FPGA SPI pins (SPI0/SPI1 chip selects, shared SCK, per-channel MOSI/MISO). It replaces CPU bit-banging of these pins through the GPIO path with byte-wide, mode-0 transfers: software writes a byte, the block shifts it out, captures the returned byte, then raises a done flag and interrupt.

## Interface
Parameters:
- DIV_W, 8: width of the SCK half-period divider field.
- DATA_BITS, 8: bits per transfer, MSB first.

Ports:
- OPB_CLK  in  1  sole clock.
- OPB_RST_N  in  1  reset, asynchronous assert, active-low.
- OPB_ADDR  in  32  register select; only [3:2] decoded.
- OPB_DI  in  32  write data.
- OPB_DO  out  32  registered read data.
- SPI_WE  in  1  single-cycle register write strobe.
- SPI_RE  in  1  single-cycle register read strobe.
- APP_FPGA_SPI_CLK  out  1  shared SCK.
- APP_FPGA_SPI0_CS_N / APP_FPGA_SPI1_CS_N  out  1 each  chip selects.
- APP_FPGA_SPI0_MOSI / APP_FPGA_SPI1_MOSI  out  1 each  serial data out.
- APP_FPGA_SPI0_MISO / APP_FPGA_SPI1_MISO  in  1 each  serial data in.
- SPI_IRQ  out  1  one-cycle pulse at transfer completion.

## Operation
- Register map by OPB_ADDR[3:2]:
  - 0 CTRL (rw): [0] cs_sel (0 = SPI0, 1 = SPI1); [1] cs_hold; [8+DIV_W-1:8] div.
  - 1 TXDATA (w): write starts a transfer when idle.
  - 2 RXDATA (r): last captured byte in [DATA_BITS-1:0]; a read clears done.
  - 3 STATUS: [0] busy, [1] done, [2] ovr. Write 1 to bit 2 clears ovr.
- TXDATA write while busy: data dropped, ovr set (sticky).
- CTRL writes while busy: register updates, but the current transfer keeps the cs_sel/div latched at its start.
- Mode 0 only:
  - SCK idles low.
  - MOSI is driven on CS assertion and after each falling edge.
  - MISO of the selected channel is sampled on each rising edge.
  - Unselected MOSI is held 0; unselected CS_N is held 1.
- FSM states:
  - IDLE to SETUP on accepted TXDATA write.
  - SETUP (CS low, MOSI = MSB) to SHIFT after one half-period.
  - SHIFT toggles SCK every half-period and goes to HOLD after the DATA_BITS-th falling edge.
  - HOLD lasts one half-period with SCK low, then DONE.
  - DONE is one cycle: sets done, pulses SPI_IRQ, latches RXDATA, deasserts CS unless cs_hold, then returns to IDLE.
- cs_hold = 1 keeps CS_N low between transfers. Writing CTRL with cs_hold = 0 while idle deasserts CS_N the next cycle.
- Half-period T = div + 1 OPB_CLK cycles; div = 0 is legal (SCK = OPB_CLK/2).

## Timing
- Reset values: OPB_DO 0; SCK 0; both CS_N 1; both MOSI 0; SPI_IRQ 0; all registers 0; FSM in IDLE.
- Reset mid-transfer forces these values immediately, with no completion and no IRQ.
- TXDATA write sampled at edge 0:
  - Edge 1: CS_N low, MOSI = bit DATA_BITS-1, busy = 1.
  - Edge 1+(2k+1)T, k = 0..DATA_BITS-1: SCK rises and MISO is sampled.
  - Edge 1+(2k+2)T: SCK falls and the next MOSI bit is driven.
  - With DATA_BITS = 8, the last fall is at edge 1+16T.
  - Edge 1+17T: busy = 0, done = 1, SPI_IRQ high for one cycle, CS_N high unless cs_hold.
- A new transfer is accepted the cycle after busy clears; back-to-back transfers with cs_hold keep CS_N low throughout.
- OPB_DO updates on the edge where SPI_RE is sampled (one-cycle read latency) and holds otherwise.
- A RXDATA read in the same cycle that done sets: set wins, and OPB_DO returns the new byte.
- TXDATA write and ovr clear in the same cycle: the ovr set wins.
- Unmapped bits read 0.

## Structure
- Package app_spi_pkg holds:
  - register offsets (CTRL/TXDATA/RXDATA/STATUS);
  - CTRL/STATUS bit positions;
  - FSM state enum (IDLE, SETUP, SHIFT, HOLD, DONE).
- Sub-module app_spi_clkgen:
  - loadable down-counter emitting a one-cycle half-period tick every div+1 cycles;
  - restarted at transfer start.
- The top level holds the register file, FSM, shift registers and bit counter.

## Test plan
- div = 0, cs_sel = 0, TXDATA = 0xA5, SPI0_MISO driven by a slave model returning 0x3C -> SPI0 shows 8 SCK pulses at OPB_CLK/2, MOSI = 10100101, SPI1 pins idle; RXDATA = 0x3C; IRQ at edge 18.
- div = 3, cs_sel = 1, TXDATA = 0x81 -> SCK half-period 4 cycles; CS1_N low for 68 cycles; busy clears at edge 69.
- cs_hold = 1, two back-to-back bytes 0x01, 0x02 -> CS_N stays low across both. Then a CTRL write with cs_hold = 0 -> CS_N high the next cycle.
- TXDATA write while busy -> no second transfer, ovr = 1; writing 1 to STATUS[2] clears it.
- Assert OPB_RST_N low at mid-bit 4 -> SCK 0, both CS_N 1, busy 0, no IRQ. A following transfer completes normally.
- RXDATA read exactly at the done-set cycle -> done stays 1 and OPB_DO equals the new byte.
